register_universal: RTL and testbench

Parametrised universal register: the multi-bit successor to the single-bit D flip-flop. Per clock it holds, parallel-loads, shifts, rotates or steps as a Johnson counter, and tracks serial-word assembly so it doubles as a serial-to-parallel converter. Used as the general storage and shift element in later experiments, such as counters, serial links and sequence generators.

---
 rtl/register_universal_pkg.sv | 17 +
 rtl/register_universal_cell.sv | 51 +++++
 rtl/register_universal.sv | 118 +++++++++++
 tb/tb_register_universal.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/register_universal_pkg.sv
// register_universal_pkg
//   Shared definitions for the universal register: the 3-bit operation
//   select encoding used by the top module and by every bit cell.
package register_universal_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD    = 3'b000,
    MODE_LOAD    = 3'b001,
    MODE_SHR     = 3'b010,
    MODE_SHL     = 3'b011,
    MODE_ROTR    = 3'b100,
    MODE_ROTL    = 3'b101,
    MODE_JOHNSON = 3'b110,
    MODE_SCLR    = 3'b111
  } mode_e;

endpackage

// File: rtl/register_universal_cell.sv
// register_universal_cell
//   One storage bit of the universal register: a next-value mux followed by
//   a flip-flop with asynchronous clear to RESET_BIT.
//   Ports:
//     clk, rst   clock, async active-high clear
//     enable     1 = apply mode this edge, 0 = hold
//     mode       operation select
//     load_bit   parallel-load value for this bit
//     from_up    bit arriving on a rightward move (shift/rotate/Johnson)
//     from_down  bit arriving on a leftward move (shift/rotate)
//     q          stored bit
module register_universal_cell
  import register_universal_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  input  mode_e mode,
  input  logic  load_bit,
  input  logic  from_up,
  input  logic  from_down,
  output logic  q
);

  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    if (enable) begin
      unique case (mode)
        MODE_HOLD:                           bit_d = bit_q;
        MODE_LOAD:                           bit_d = load_bit;
        MODE_SHR, MODE_ROTR, MODE_JOHNSON:   bit_d = from_up;
        MODE_SHL, MODE_ROTL:                 bit_d = from_down;
        MODE_SCLR:                           bit_d = RESET_BIT;
        default:                             bit_d = bit_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bit_q <= RESET_BIT;
    else     bit_q <= bit_d;
  end

  assign q = bit_q;

endmodule

// File: rtl/register_universal.sv
// register_universal
//   Parametrised universal register: hold, parallel load, shift right/left,
//   rotate right/left, Johnson step and sync clear, plus a shift counter
//   with a word_ready flag for serial-to-parallel assembly.
//   Ports:
//     clockpulse      clock (rising edge)
//     clear           async active-high reset
//     enable          1 = execute mode this edge, 0 = freeze all state
//     mode            operation select (register_universal_pkg::mode_e)
//     data            parallel load value
//     serial_in_msb   bit entering at MSB on shift right
//     serial_in_lsb   bit entering at LSB on shift left
//     signal_q        register contents
//     signal_q_       bitwise complement of signal_q
//     serial_out_lsb  signal_q[0]
//     serial_out_msb  signal_q[WIDTH-1]
//     shift_count     shifts since last load/clear, 0..WIDTH
//     word_ready      high while shift_count == WIDTH
module register_universal
  import register_universal_pkg::*;
#(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic                       clockpulse,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           data,
  input  logic                       serial_in_msb,
  input  logic                       serial_in_lsb,
  output logic [WIDTH-1:0]           signal_q,
  output logic [WIDTH-1:0]           signal_q_,
  output logic                       serial_out_lsb,
  output logic                       serial_out_msb,
  output logic [$clog2(WIDTH+1)-1:0] shift_count,
  output logic                       word_ready
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] up_vec;
  logic [WIDTH-1:0] down_vec;
  logic             fill_msb;
  logic             fill_lsb;

  assign mode_sel = mode_e'(mode);

  // Bit entering at the ends depends on which right/left operation is active;
  // interior bits always take their neighbour.
  always_comb begin
    fill_msb = serial_in_msb;
    fill_lsb = serial_in_lsb;
    unique case (mode_sel)
      MODE_ROTR:    fill_msb = q_vec[0];
      MODE_JOHNSON: fill_msb = ~q_vec[0];
      MODE_ROTL:    fill_lsb = q_vec[WIDTH-1];
      default: ;
    endcase
  end

  assign up_vec   = {fill_msb, q_vec[WIDTH-1:1]};
  assign down_vec = {q_vec[WIDTH-2:0], fill_lsb};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    register_universal_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk       (clockpulse),
      .rst       (clear),
      .enable    (enable),
      .mode      (mode_sel),
      .load_bit  (data[i]),
      .from_up   (up_vec[i]),
      .from_down (down_vec[i]),
      .q         (q_vec[i])
    );
  end

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          word_ready_q;
  logic          word_ready_d;

  always_comb begin
    count_d = count_q;
    if (enable) begin
      unique case (mode_sel)
        MODE_LOAD, MODE_SCLR: count_d = '0;
        // A full word wraps to 1 so the next word assembles without a reload.
        MODE_SHR, MODE_SHL:   count_d = (count_q == FULL) ? CW'(1) : count_q + CW'(1);
        default:              count_d = count_q;
      endcase
    end
    word_ready_d = (count_d == FULL);
  end

  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      count_q      <= '0;
      word_ready_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      word_ready_q <= word_ready_d;
    end
  end

  assign signal_q       = q_vec;
  assign signal_q_      = ~q_vec;
  assign serial_out_lsb = q_vec[0];
  assign serial_out_msb = q_vec[WIDTH-1];
  assign shift_count    = count_q;
  assign word_ready     = word_ready_q;

endmodule

// File: tb/tb_register_universal.sv
module tb_register_universal;
  import register_universal_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic         enable;
  logic [2:0]   mode;
  logic [W-1:0] data;
  logic         serial_in_msb;
  logic         serial_in_lsb;
  logic [W-1:0] signal_q;
  logic [W-1:0] signal_q_;
  logic         serial_out_lsb;
  logic         serial_out_msb;
  logic [2:0]   shift_count;
  logic         word_ready;

  register_universal #(
    .WIDTH       (W),
    .RESET_VALUE (4'b0000)
  ) dut (
    .clockpulse     (clk),
    .clear          (clear),
    .enable         (enable),
    .mode           (mode),
    .data           (data),
    .serial_in_msb  (serial_in_msb),
    .serial_in_lsb  (serial_in_lsb),
    .signal_q       (signal_q),
    .signal_q_      (signal_q_),
    .serial_out_lsb (serial_out_lsb),
    .serial_out_msb (serial_out_msb),
    .shift_count    (shift_count),
    .word_ready     (word_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [2:0]   cnt;
    logic         rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic sample_req = 1'b0;

  // Monitor: each sample request drains the scoreboard against the live outputs.
  initial begin
    forever begin
      @(sample_req);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [W-1:0] eqn;
        e   = exp_q.pop_front();
        eqn = ~e.q;
        n_vec++;
        if (signal_q !== e.q || signal_q_ !== eqn || serial_out_lsb !== e.q[0] ||
            serial_out_msb !== e.q[W-1] || shift_count !== e.cnt || word_ready !== e.rdy) begin
          n_bad++;
          $display("FAIL %s: got q=%b q_=%b lsb=%b msb=%b cnt=%0d rdy=%b, want q=%b q_=%b lsb=%b msb=%b cnt=%0d rdy=%b",
                   e.name, signal_q, signal_q_, serial_out_lsb, serial_out_msb, shift_count, word_ready,
                   e.q, eqn, e.q[0], e.q[W-1], e.cnt, e.rdy);
        end
      end
    end
  end

  task automatic expect_now(input string nm, input logic [W-1:0] q, input logic [2:0] c, input logic r);
    exp_t e;
    e.name = nm; e.q = q; e.cnt = c; e.rdy = r;
    exp_q.push_back(e);
    sample_req = ~sample_req;
    #1;
  endtask

  task automatic step(input logic en, input logic [2:0] m, input logic [W-1:0] d,
                      input logic smsb, input logic slsb, input string nm,
                      input logic [W-1:0] q, input logic [2:0] c, input logic r);
    enable = en; mode = m; data = d; serial_in_msb = smsb; serial_in_lsb = slsb;
    @(posedge clk);
    #1;
    expect_now(nm, q, c, r);
  endtask

  task automatic clear_pulse(input string nm);
    #1 clear = 1'b1;
    #1 expect_now(nm, 4'b0000, 3'd0, 1'b0);
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] jseq [8];
    logic [3:0] rseq [4];
    jseq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    rseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    clear = 1'b0; enable = 1'b1; mode = MODE_LOAD; data = 4'hF;
    serial_in_msb = 1'b0; serial_in_lsb = 1'b0;
    #2 clear = 1'b1;
    #1 expect_now("clear_async", 4'b0000, 3'd0, 1'b0);
    @(posedge clk); #1 expect_now("clear_held_e1", 4'b0000, 3'd0, 1'b0);
    @(posedge clk); #1 expect_now("clear_held_e2", 4'b0000, 3'd0, 1'b0);
    // release while clock is high: nothing changes until the next rising edge
    clear = 1'b0;
    #1 expect_now("release_no_edge", 4'b0000, 3'd0, 1'b0);
    @(posedge clk); #1 expect_now("load_after_release", 4'hF, 3'd0, 1'b0);

    step(1'b1, MODE_LOAD, 4'b1010, 1'b0, 1'b0, "load_1010", 4'b1010, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, MODE_SHR, 4'b0000, 1'b1, 1'b1, "enable_low_freeze", 4'b1010, 3'd0, 1'b0);

    step(1'b1, MODE_SHR, 4'b0000, 1'b1, 1'b0, "shr1", 4'b1101, 3'd1, 1'b0);
    step(1'b1, MODE_SHR, 4'b0000, 1'b0, 1'b0, "shr2", 4'b0110, 3'd2, 1'b0);
    step(1'b1, MODE_SHR, 4'b0000, 1'b1, 1'b0, "shr3", 4'b1011, 3'd3, 1'b0);
    step(1'b1, MODE_SHR, 4'b0000, 1'b1, 1'b0, "shr4_ready", 4'b1101, 3'd4, 1'b1);
    step(1'b1, MODE_HOLD, 4'b0000, 1'b0, 1'b0, "hold_ready", 4'b1101, 3'd4, 1'b1);
    step(1'b1, MODE_ROTR, 4'b0000, 1'b0, 1'b0, "rotr_keeps_count", 4'b1110, 3'd4, 1'b1);
    step(1'b1, MODE_SHR, 4'b0000, 1'b0, 1'b0, "shr5_wrap", 4'b0111, 3'd1, 1'b0);

    step(1'b1, MODE_LOAD, 4'b0001, 1'b0, 1'b0, "load_0001", 4'b0001, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, MODE_ROTL, 4'b0000, 1'b1, 1'b1, "rotl", rseq[i], 3'd0, 1'b0);
    step(1'b1, MODE_LOAD, 4'b1000, 1'b0, 1'b0, "load_1000", 4'b1000, 3'd0, 1'b0);
    step(1'b1, MODE_SHL, 4'b0000, 1'b1, 1'b0, "shl_msb_out", 4'b0000, 3'd1, 1'b0);
    step(1'b1, MODE_SHL, 4'b0000, 1'b0, 1'b1, "shl_lsb_in", 4'b0001, 3'd2, 1'b0);

    clear_pulse("clear_before_johnson");
    for (int i = 0; i < 8; i++)
      step(1'b1, MODE_JOHNSON, 4'b0000, 1'b0, 1'b0, "johnson", jseq[i], 3'd0, 1'b0);

    step(1'b1, MODE_SHR, 4'b0000, 1'b1, 1'b0, "pre_clear_shr1", 4'b1000, 3'd1, 1'b0);
    step(1'b1, MODE_SHR, 4'b0000, 1'b1, 1'b0, "pre_clear_shr2", 4'b1100, 3'd2, 1'b0);
    clear_pulse("clear_mid_shift");
    step(1'b1, MODE_SHR, 4'b0000, 1'b1, 1'b0, "shr_after_clear", 4'b1000, 3'd1, 1'b0);
    step(1'b1, MODE_SHR, 4'b0000, 1'b0, 1'b0, "shr_b2", 4'b0100, 3'd2, 1'b0);
    step(1'b1, MODE_SHR, 4'b0000, 1'b0, 1'b0, "shr_b3", 4'b0010, 3'd3, 1'b0);
    step(1'b1, MODE_SHR, 4'b0000, 1'b0, 1'b0, "shr_b4_ready", 4'b0001, 3'd4, 1'b1);
    step(1'b1, MODE_SCLR, 4'b1111, 1'b1, 1'b1, "sclr", 4'b0000, 3'd0, 1'b0);
    step(1'b1, MODE_LOAD, 4'b0110, 1'b0, 1'b0, "load_0110", 4'b0110, 3'd0, 1'b0);
    step(1'b1, MODE_SHL, 4'b0000, 1'b0, 1'b1, "shl_after_load", 4'b1101, 3'd1, 1'b0);

    #5;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
